// File: rtl/wide_add_if.sv
// rtl/wide_add_if.sv - operand/result handshake bundle for wide_add_sequencer
//
// Purpose: groups the command side (in_valid/in_ready, op_sub, cin, a, b) and
// the result side (out_valid/out_ready, s, carryout, overflow) of the
// multi-precision add/subtract sequencer.
// Ports (signals):
//    in_valid, op_sub, cin, a[W], b[W]   producer -> sequencer
//    in_ready                            sequencer -> producer
//    out_valid, s[W], carryout, overflow sequencer -> consumer
//    out_ready                           consumer -> sequencer
// Modports: master = producer/consumer side, slave = sequencer side.
interface wide_add_if #(
   parameter int N     = 8,
   parameter int WORDS = 4
);
   localparam int W = N * WORDS;

   logic         in_valid;
   logic         in_ready;
   logic         op_sub;
   logic         cin;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] s;
   logic         carryout;
   logic         overflow;

   modport master (
      output in_valid, op_sub, cin, a, b, out_ready,
      input  in_ready, out_valid, s, carryout, overflow
   );

   modport slave (
      input  in_valid, op_sub, cin, a, b, out_ready,
      output in_ready, out_valid, s, carryout, overflow
   );
endinterface

// File: rtl/wide_add_sequencer.sv
// rtl/wide_add_sequencer.sv - multi-cycle WORDS x N-bit add/subtract on one N-bit slice
//
// Purpose: builds a W = N*WORDS bit add or subtract from a single N-bit
// ripple slice, one word per cycle, least-significant word first, with the
// inter-word carry held in a register.
// Ports:
//    clk     rising-edge clock
//    resetn  synchronous active-low reset
//    bus     wide_add_if.slave (command in, result out, valid/ready each side)
module wide_add_sequencer #(
   parameter int N     = 8,
   parameter int WORDS = 4
) (
   input logic       clk,
   input logic       resetn,
   wide_add_if.slave bus
);
   localparam int W  = N * WORDS;
   localparam int IW = $clog2(WORDS);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t         state_q, state_d;
   logic [W-1:0]   a_q, b_q, s_q;
   logic           carry_q;
   logic           carryout_q, overflow_q;
   logic [IW-1:0]  idx_q;

   logic [N-1:0]   a_word, b_word, sum_word;
   logic           slice_cout;
   logic           last_word;
   logic           accept;
   logic           in_ready_d, out_valid_d;

   // Shared N-bit slice: the only adder in the design, so the critical path
   // is one N-bit ripple regardless of WORDS.
   always_comb begin
      a_word = a_q[int'(idx_q)*N +: N];
      b_word = b_q[int'(idx_q)*N +: N];
      {slice_cout, sum_word} = {1'b0, a_word} + {1'b0, b_word} + {{N{1'b0}}, carry_q};
   end

   assign last_word = (idx_q == IW'(WORDS - 1));
   assign accept    = (state_q == IDLE) && bus.in_valid;

   always_ff @(posedge clk) begin
      if (!resetn) state_q <= IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d     = state_q;
      in_ready_d  = 1'b0;
      out_valid_d = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready_d = 1'b1;
            if (bus.in_valid) state_d = RUN;
         end
         RUN: begin
            if (last_word) state_d = DONE;
         end
         DONE: begin
            out_valid_d = 1'b1;
            if (bus.out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         a_q        <= '0;
         b_q        <= '0;
         s_q        <= '0;
         carry_q    <= 1'b0;
         idx_q      <= '0;
         carryout_q <= 1'b0;
         overflow_q <= 1'b0;
      end else if (accept) begin
         // Subtract is A + ~B + 1: invert B once here and seed the carry.
         a_q     <= bus.a;
         b_q     <= bus.op_sub ? ~bus.b : bus.b;
         carry_q <= bus.op_sub | bus.cin;
         idx_q   <= '0;
      end else if (state_q == RUN) begin
         s_q[int'(idx_q)*N +: N] <= sum_word;
         carry_q                 <= slice_cout;
         idx_q                   <= idx_q + 1'b1;
         if (last_word) begin
            carryout_q <= slice_cout;
            // carry into the MSB xor carry out of it, using the stored B MSB
            overflow_q <= a_word[N-1] ^ b_word[N-1] ^ sum_word[N-1] ^ slice_cout;
         end
      end
   end

   assign bus.in_ready  = in_ready_d;
   assign bus.out_valid = out_valid_d;
   assign bus.s         = s_q;
   assign bus.carryout  = carryout_q;
   assign bus.overflow  = overflow_q;
endmodule

// File: tb/tb_wide_add_sequencer.sv
// tb/tb_wide_add_sequencer.sv - directed self-checking bench for wide_add_sequencer
module tb_wide_add_sequencer;
   logic clk;
   logic resetn;
   int   n_total;
   int   n_pass;

   wide_add_if #(.N(8), .WORDS(4)) bus ();

   wide_add_sequencer #(.N(8), .WORDS(4)) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Presents an operation and returns 1ns after its accept edge.
   task automatic start_op(input logic [31:0] a_v, input logic [31:0] b_v,
                           input logic sub_v, input logic cin_v);
      int cyc;
      @(negedge clk);
      bus.a        = a_v;
      bus.b        = b_v;
      bus.op_sub   = sub_v;
      bus.cin      = cin_v;
      bus.in_valid = 1'b1;
      cyc = 0;
      while (!bus.in_ready && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      chk("accept_ready", {63'd0, bus.in_ready}, 64'd1);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
   endtask

   // Counts edges from accept until out_valid is seen; returns in DONE.
   task automatic wait_done(output int lat);
      lat = 0;
      do begin
         @(posedge clk);
         #1;
         lat++;
      end while (!bus.out_valid && lat < 20);
   endtask

   task automatic check_result(input string tag, input logic [31:0] s_e,
                               input logic co_e, input logic ov_e);
      @(negedge clk);
      chk({tag, "_s"},  {32'd0, bus.s}, {32'd0, s_e});
      chk({tag, "_co"}, {63'd0, bus.carryout}, {63'd0, co_e});
      chk({tag, "_ov"}, {63'd0, bus.overflow}, {63'd0, ov_e});
   endtask

   task automatic consume(input string tag);
      @(negedge clk);
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      @(negedge clk);
      chk({tag, "_idle_ready"}, {63'd0, bus.in_ready}, 64'd1);
      chk({tag, "_idle_valid"}, {63'd0, bus.out_valid}, 64'd0);
   endtask

   task automatic directed(input string tag, input logic [31:0] a_v, input logic [31:0] b_v,
                           input logic sub_v, input logic cin_v, input logic [31:0] s_e,
                           input logic co_e, input logic ov_e);
      int lat;
      start_op(a_v, b_v, sub_v, cin_v);
      wait_done(lat);
      chk({tag, "_latency"}, 64'(lat), 64'd4);
      check_result(tag, s_e, co_e, ov_e);
      consume(tag);
   endtask

   // Independent W-bit reference: full-width arithmetic, overflow from signs.
   task automatic ref_model(input logic [31:0] a_v, input logic [31:0] b_v,
                            input logic sub_v, input logic cin_v,
                            output logic [31:0] s_e, output logic co_e, output logic ov_e);
      logic [31:0] bv;
      logic [32:0] full;
      bv   = sub_v ? -b_v : b_v;
      full = {1'b0, a_v} + {1'b0, (sub_v ? ~b_v : b_v)} + 33'(sub_v | cin_v);
      s_e  = full[31:0];
      co_e = full[32];
      if (sub_v) ov_e = (a_v[31] != b_v[31]) && (s_e[31] != a_v[31]);
      else       ov_e = (a_v[31] == bv[31]) && (s_e[31] != a_v[31]);
   endtask

   logic [31:0] op_a [3];
   logic [31:0] op_b [3];
   logic        op_s [3];
   logic        op_c [3];
   logic [31:0] exp_s [3];
   logic        exp_co [3];
   logic        exp_ov [3];

   initial begin
      int lat;
      int cyc, nacc, nres, last_acc;
      n_total       = 0;
      n_pass        = 0;
      resetn        = 1'b0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus.op_sub    = 1'b0;
      bus.cin       = 1'b0;
      bus.a         = '0;
      bus.b         = '0;
      repeat (3) @(posedge clk);
      #1;
      resetn = 1'b1;

      // Reset state
      @(negedge clk);
      chk("rst_in_ready",  {63'd0, bus.in_ready},  64'd1);
      chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
      chk("rst_s",         {32'd0, bus.s},         64'd0);
      chk("rst_co",        {63'd0, bus.carryout},  64'd0);
      chk("rst_ov",        {63'd0, bus.overflow},  64'd0);

      // Arithmetic corner cases
      directed("add_ripple", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
      directed("sub_borrow", 32'd5, 32'd7, 1'b1, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0);
      directed("sub_noborrow", 32'd7, 32'd5, 1'b1, 1'b1, 32'd2, 1'b1, 1'b0);
      directed("add_ovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
      directed("sub_ovf", 32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1);

      // Backpressure in DONE with new operands offered
      start_op(32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0);
      wait_done(lat);
      chk("bp_latency", 64'(lat), 64'd4);
      bus.in_valid = 1'b1;
      bus.a        = 32'hAAAA_AAAA;
      bus.b        = 32'h5555_5555;
      bus.op_sub   = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("bp_s",         {32'd0, bus.s},         64'h0001_0000);
         chk("bp_co",        {63'd0, bus.carryout},  64'd0);
         chk("bp_ov",        {63'd0, bus.overflow},  64'd0);
         chk("bp_in_ready",  {63'd0, bus.in_ready},  64'd0);
         chk("bp_out_valid", {63'd0, bus.out_valid}, 64'd1);
      end
      @(posedge clk);
      #1;
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b0;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      @(negedge clk);
      chk("bp_after_ready", {63'd0, bus.in_ready},  64'd1);
      chk("bp_after_valid", {63'd0, bus.out_valid}, 64'd0);
      chk("bp_s_kept",      {32'd0, bus.s},         64'h0001_0000);

      // Back-to-back with in_valid and out_ready held high
      op_a[0] = 32'h1234_5678; op_b[0] = 32'h1111_1111; op_s[0] = 1'b0; op_c[0] = 1'b1;
      op_a[1] = $urandom;      op_b[1] = $urandom;      op_s[1] = 1'b1; op_c[1] = 1'b0;
      op_a[2] = $urandom;      op_b[2] = $urandom;      op_s[2] = 1'b0; op_c[2] = 1'b1;
      for (int i = 0; i < 3; i++)
         ref_model(op_a[i], op_b[i], op_s[i], op_c[i], exp_s[i], exp_co[i], exp_ov[i]);
      chk("b2b_ref_cin", {32'd0, exp_s[0]}, 64'h2345_678A);
      @(negedge clk);
      bus.a = op_a[0]; bus.b = op_b[0]; bus.op_sub = op_s[0]; bus.cin = op_c[0];
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b1;
      cyc = 0; nacc = 0; nres = 0; last_acc = 0;
      while (nres < 3 && cyc < 60) begin
         if (cyc > 0) @(negedge clk);
         cyc++;
         if (bus.out_valid) begin
            chk("b2b_s",  {32'd0, bus.s},        {32'd0, exp_s[nres]});
            chk("b2b_co", {63'd0, bus.carryout}, {63'd0, exp_co[nres]});
            chk("b2b_ov", {63'd0, bus.overflow}, {63'd0, exp_ov[nres]});
            nres++;
         end
         if (bus.in_ready && nacc < 3) begin
            if (nacc > 0) chk("b2b_spacing", 64'(cyc - last_acc), 64'd6);
            last_acc = cyc;
            nacc++;
            @(posedge clk);
            #1;
            if (nacc < 3) begin
               bus.a = op_a[nacc]; bus.b = op_b[nacc];
               bus.op_sub = op_s[nacc]; bus.cin = op_c[nacc];
            end else begin
               bus.in_valid = 1'b0;
            end
         end
      end
      chk("b2b_results", 64'(nres), 64'd3);
      bus.in_valid = 1'b0;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;

      // Reset two edges into an operation
      start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1);
      @(posedge clk);
      #1;
      resetn = 1'b0;
      @(posedge clk);
      #1;
      resetn = 1'b1;
      @(negedge clk);
      chk("abort_in_ready",  {63'd0, bus.in_ready},  64'd1);
      chk("abort_out_valid", {63'd0, bus.out_valid}, 64'd0);
      chk("abort_s",         {32'd0, bus.s},         64'd0);
      chk("abort_co",        {63'd0, bus.carryout},  64'd0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("abort_no_valid", {63'd0, bus.out_valid}, 64'd0);
      end
      directed("post_abort", 32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0, 32'h0000_0003, 1'b0, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
